// File: rtl/vga_noise_colorizer_pkg.sv
// Shared constants for the VGA noise colorizer: palette indices, the 4x4
// ordered-dither table and sync polarity helpers.
package vga_noise_pkg;

    localparam logic [1:0] PAL_GRAY  = 2'd0;
    localparam logic [1:0] PAL_FIRE  = 2'd1;
    localparam logic [1:0] PAL_OCEAN = 2'd2;
    localparam logic [1:0] PAL_RAW   = 2'd3;

    // Indexed [y][x].
    localparam logic [3:0] BAYER4X4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    // Level a sync line rests at when not asserted.
    function automatic logic sync_idle_level(input logic active_low);
        return active_low;
    endfunction

    // True when the line level means "sync asserted".
    function automatic logic sync_asserted(input logic level, input logic active_low);
        return level ^ active_low;
    endfunction

endpackage

// File: rtl/vga_noise_colorizer_sync_delay_line.sv
// Fixed-depth shift register with a configurable reset fill value. DEPTH=0
// degenerates to a plain wire.
module sync_delay_line #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_reset;
        assign unused_clk_reset = clk ^ reset;
        assign d_out = d_in;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        // Each stage takes the value of the one before it.
        always_comb begin
            stage_d[0] = d_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // Stage registers, filled with RESET_VAL on reset.
        always_ff @(posedge clk) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (reset) begin
                    stage_q[i] <= RESET_VAL;
                end else begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign d_out = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_noise_colorizer.sv
// Output stage of the VGA noise demo: aligns sync/active/position with the
// noise pipeline, optionally dithers, maps through a frame-rotated palette
// and registers the pin outputs.
// Define VGA_NOISE_DITHER_EN to enable the 4x4 ordered dither; otherwise the
// x/y inputs are ignored and the top nibble of the noise is used directly.
module vga_noise_colorizer
    import vga_noise_pkg::*;
#(
    parameter int unsigned NOISE_LAT        = 1,
    parameter int unsigned FRAMES_PER_PAL   = 60,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter bit          HSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active_in,
    input  logic [1:0] x_in,
    input  logic [1:0] y_in,
    input  logic [7:0] noise_in,
    input  logic       pal_force_en,
    input  logic [1:0] pal_force_idx,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [5:0] rrggbb_out,
    output logic [1:0] palette_idx,
    output logic       frame_start
);

    localparam logic HS_IDLE = sync_idle_level(HSYNC_ACTIVE_LOW);
    localparam logic VS_IDLE = sync_idle_level(VSYNC_ACTIVE_LOW);
    localparam int unsigned CNT_W = (FRAMES_PER_PAL > 1) ? $clog2(FRAMES_PER_PAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PAL - 1);

`ifdef VGA_NOISE_DITHER_EN
    localparam int unsigned BW = 7;
    localparam logic [BW-1:0] BUNDLE_IDLE = {HS_IDLE, VS_IDLE, 1'b0, 4'b0000};
`else
    localparam int unsigned BW = 3;
    localparam logic [BW-1:0] BUNDLE_IDLE = {HS_IDLE, VS_IDLE, 1'b0};
`endif

    logic [BW-1:0] bundle_in;
    logic [BW-1:0] bundle_a;
    logic          hsync_a;
    logic          vsync_a;
    logic          active_a;
    logic [3:0]    n4;
    logic          unused_bits;

    logic [5:0]       rgb_d, rgb_q;
    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;
    logic             frame_start_d, frame_start_q;
    logic [1:0]       palette_idx_d, palette_idx_q;
    logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;

`ifdef VGA_NOISE_DITHER_EN
    logic [1:0] x_a, y_a;
    logic [8:0] sum9;
    logic [7:0] sat;

    assign bundle_in = {hsync_in, vsync_in, active_in, x_in, y_in};
    assign x_a       = bundle_a[3:2];
    assign y_a       = bundle_a[1:0];
    assign sum9      = {1'b0, noise_in} + {5'b00000, BAYER4X4[y_a][x_a]};
    assign sat       = sum9[8] ? 8'hFF : sum9[7:0];
    assign n4        = sat[7:4];
    assign unused_bits = ^sat[3:0];
`else
    assign bundle_in   = {hsync_in, vsync_in, active_in};
    assign n4          = noise_in[7:4];
    assign unused_bits = ^{x_in, y_in, noise_in[1:0]};
`endif

    sync_delay_line #(
        .WIDTH     (BW),
        .DEPTH     (NOISE_LAT),
        .RESET_VAL (BUNDLE_IDLE)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .d_in  (bundle_in),
        .d_out (bundle_a)
    );

    assign hsync_a  = bundle_a[BW-1];
    assign vsync_a  = bundle_a[BW-2];
    assign active_a = bundle_a[BW-3];

    // Palette mapping of the aligned pixel; blanked outside active video.
    always_comb begin
        rgb_d   = '0;
        hsync_d = hsync_a;
        vsync_d = vsync_a;
        if (active_a) begin
            case (palette_idx_q)
                PAL_GRAY:  rgb_d = {n4[3:2], n4[3:2], n4[3:2]};
                PAL_FIRE:  rgb_d = {(n4[3] ? 2'b11 : n4[2:1]), n4[3:2],
                                    ((n4 == 4'hF) ? 2'b11 : 2'b00)};
                PAL_OCEAN: rgb_d = {2'b00, n4[3:2], (n4[3] ? 2'b11 : n4[2:1])};
                PAL_RAW:   rgb_d = noise_in[7:2];
                default:   rgb_d = '0;
            endcase
        end
    end

    // Frame-start edge detect (vsync_q is the previous aligned vsync) and
    // palette rotation; the force inputs only matter at a frame start.
    always_comb begin
        frame_start_d = sync_asserted(vsync_a, VSYNC_ACTIVE_LOW) &&
                        !sync_asserted(vsync_q, VSYNC_ACTIVE_LOW);
        palette_idx_d = palette_idx_q;
        frame_cnt_d   = frame_cnt_q;
        if (frame_start_d) begin
            if (pal_force_en) begin
                palette_idx_d = pal_force_idx;
                frame_cnt_d   = '0;
            end else if (frame_cnt_q == CNT_LAST) begin
                palette_idx_d = palette_idx_q + 2'd1;
                frame_cnt_d   = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    // Output and frame-state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q         <= '0;
            hsync_q       <= HS_IDLE;
            vsync_q       <= VS_IDLE;
            frame_start_q <= 1'b0;
            palette_idx_q <= PAL_GRAY;
            frame_cnt_q   <= '0;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            palette_idx_q <= palette_idx_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign rrggbb_out  = rgb_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign frame_start = frame_start_q;
    assign palette_idx = palette_idx_q;

endmodule

// File: tb/tb_vga_noise_colorizer.sv
// Self-checking bench for vga_noise_colorizer with NOISE_LAT=3 and
// FRAMES_PER_PAL=2, using a queue-based reference model of the pixel path.
module tb_vga_noise_colorizer;

    localparam int L   = 3;
    localparam int FPP = 2;
`ifdef VGA_NOISE_DITHER_EN
    localparam int DITHER = 1;
`else
    localparam int DITHER = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in, active_in;
    logic [1:0] x_in, y_in;
    logic [7:0] noise_in;
    logic       pal_force_en;
    logic [1:0] pal_force_idx;
    logic       hsync_out, vsync_out, frame_start;
    logic [5:0] rrggbb_out;
    logic [1:0] palette_idx;

    vga_noise_colorizer #(
        .NOISE_LAT        (L),
        .FRAMES_PER_PAL   (FPP),
        .VSYNC_ACTIVE_LOW (1'b1),
        .HSYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .active_in     (active_in),
        .x_in          (x_in),
        .y_in          (y_in),
        .noise_in      (noise_in),
        .pal_force_en  (pal_force_en),
        .pal_force_idx (pal_force_idx),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .rrggbb_out    (rrggbb_out),
        .palette_idx   (palette_idx),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    typedef struct {
        logic       h;
        logic       v;
        logic       act;
        logic [1:0] x;
        logic [1:0] y;
    } px_t;

    px_t        pipe[$];
    logic       exp_h, exp_v, exp_fs;
    logic [5:0] exp_rgb;
    int         exp_pal;
    int         frames_on_pal;
    int         model_fs_cnt = 0;
    int         dut_fs_cnt   = 0;
    int         bayer_ref [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    function automatic logic [5:0] ref_colour(input int pal, input int noise, input int x,
                                              input int y);
        int s, n, rr, gg, bb;
        s = noise + DITHER * bayer_ref[y * 4 + x];
        if (s > 255) s = 255;
        n = s / 16;
        case (pal)
            0: begin rr = n / 4; gg = n / 4; bb = n / 4; end
            1: begin rr = (n >= 8) ? 3 : (n / 2) % 4; gg = n / 4; bb = (n == 15) ? 3 : 0; end
            2: begin rr = 0; gg = n / 4; bb = (n >= 8) ? 3 : (n / 2) % 4; end
            default: return 6'(noise / 4);
        endcase
        return 6'(rr * 16 + gg * 4 + bb);
    endfunction

    // One clock: advance the model on the edge, then let the DUT settle.
    task automatic cycle();
        px_t cur, al;
        logic fs;
        @(posedge clk);
        if (reset) begin
            pipe.delete();
            for (int i = 0; i < L; i++) pipe.push_back('{1'b1, 1'b1, 1'b0, 2'd0, 2'd0});
            exp_h = 1'b1; exp_v = 1'b1; exp_fs = 1'b0; exp_rgb = '0;
            exp_pal = 0; frames_on_pal = 0;
        end else begin
            cur = '{hsync_in, vsync_in, active_in, x_in, y_in};
            pipe.push_back(cur);
            al = pipe.pop_front();
            exp_rgb = al.act ? ref_colour(exp_pal, int'(noise_in), int'(al.x), int'(al.y))
                             : 6'd0;
            fs = (al.v == 1'b0) && (exp_v == 1'b1);
            exp_h = al.h; exp_v = al.v; exp_fs = fs;
            if (fs) begin
                model_fs_cnt++;
                if (pal_force_en) begin
                    exp_pal = int'(pal_force_idx); frames_on_pal = 0;
                end else begin
                    frames_on_pal++;
                    if (frames_on_pal == FPP) begin
                        frames_on_pal = 0; exp_pal = (exp_pal + 1) % 4;
                    end
                end
            end
        end
        #1;
        if (frame_start === 1'b1) dut_fs_cnt++;
    endtask

    task automatic idle_inputs();
        hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
        x_in = 2'd0; y_in = 2'd0; noise_in = 8'd0;
        pal_force_en = 1'b0; pal_force_idx = 2'd0;
    endtask

    // One vsync assertion followed by enough cycles for it to leave the pipe.
    task automatic vpulse();
        vsync_in = 1'b0;
        cycle();
        vsync_in = 1'b1;
        repeat (L + 2) cycle();
    endtask

    task automatic hold(input logic act, input logic [1:0] x, input logic [1:0] y,
                        input logic [7:0] nz);
        active_in = act; x_in = x; y_in = y; noise_in = nz;
        repeat (L + 2) cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (L + 3) begin
            cycle();
            n_checks += 5;
            if (rrggbb_out !== 6'd0) begin n_fail++;
                $display("FAIL reset_rgb: got %h want 00", rrggbb_out); end
            if (hsync_out !== 1'b1) begin n_fail++;
                $display("FAIL reset_hsync: got %b want 1", hsync_out); end
            if (vsync_out !== 1'b1) begin n_fail++;
                $display("FAIL reset_vsync: got %b want 1", vsync_out); end
            if (palette_idx !== 2'd0) begin n_fail++;
                $display("FAIL reset_pal: got %0d want 0", palette_idx); end
            if (frame_start !== 1'b0) begin n_fail++;
                $display("FAIL reset_fs: got %b want 0", frame_start); end
        end
    endtask

    task automatic test_latency();
        int seen;
        seen = -1;
        hsync_in = 1'b0;
        for (int k = 1; k <= 10 && seen < 0; k++) begin
            cycle();
            if (hsync_out === 1'b0) seen = k;
        end
        n_checks++;
        if (seen != L + 1) begin n_fail++;
            $display("FAIL hsync_latency: got %0d cycles want %0d", seen, L + 1); end
        hsync_in = 1'b1;
        repeat (L + 2) cycle();
        // Raw palette: force P3, then a single 0xFC sample shows one cycle later.
        pal_force_en = 1'b1; pal_force_idx = 2'd3;
        vpulse();
        pal_force_en = 1'b0;
        hold(1'b1, 2'd0, 2'd0, 8'h00);
        noise_in = 8'hFC;
        cycle();
        n_checks++;
        if (rrggbb_out !== 6'h3F || exp_rgb !== 6'h3F) begin n_fail++;
            $display("FAIL raw_fc: got %h want 3f", rrggbb_out); end
        noise_in = 8'h00;
        cycle();
        n_checks++;
        if (rrggbb_out !== 6'h00) begin n_fail++;
            $display("FAIL raw_after: got %h want 00", rrggbb_out); end
        active_in = 1'b0;
    endtask

    task automatic force_pal(input logic [1:0] p);
        active_in = 1'b0;
        pal_force_en = 1'b1; pal_force_idx = p;
        vpulse();
        pal_force_en = 1'b0;
    endtask

    task automatic test_dither();
`ifdef VGA_NOISE_DITHER_EN
        force_pal(2'd0);
        hold(1'b1, 2'd0, 2'd0, 8'h78);
        n_checks++;
        if (rrggbb_out !== 6'b010101) begin n_fail++;
            $display("FAIL dither_78: got %b want 010101", rrggbb_out); end
        hold(1'b1, 2'd0, 2'd3, 8'h87);
        n_checks++;
        if (rrggbb_out !== 6'b101010) begin n_fail++;
            $display("FAIL dither_87: got %b want 101010", rrggbb_out); end
        hold(1'b1, 2'd0, 2'd3, 8'hFF);
        n_checks++;
        if (rrggbb_out !== 6'h3F) begin n_fail++;
            $display("FAIL dither_sat: got %h want 3f", rrggbb_out); end
`else
        force_pal(2'd0);
        hold(1'b1, 2'd3, 2'd3, 8'h78);
        n_checks++;
        if (rrggbb_out !== 6'b010101) begin n_fail++;
            $display("FAIL nodither_78: got %b want 010101", rrggbb_out); end
`endif
        active_in = 1'b0;
    endtask

    task automatic test_palettes();
        force_pal(2'd1);
        hold(1'b1, 2'd0, 2'd0, 8'hF0);
        n_checks++;
        if (rrggbb_out !== 6'b111111) begin n_fail++;
            $display("FAIL fire_15: got %b want 111111", rrggbb_out); end
        force_pal(2'd2);
        hold(1'b1, 2'd0, 2'd0, 8'h80);
        n_checks++;
        if (rrggbb_out !== 6'b001011) begin n_fail++;
            $display("FAIL ocean_8: got %b want 001011", rrggbb_out); end
        active_in = 1'b0;
    endtask

    task automatic test_rotation();
        int fs0;
        idle_inputs();
        reset = 1'b1; cycle(); reset = 1'b0;
        fs0 = dut_fs_cnt;
        for (int k = 1; k <= 8; k++) begin
            vpulse();
            n_checks++;
            if (int'(palette_idx) != (k / 2) % 4) begin n_fail++;
                $display("FAIL rotate_%0d: got %0d want %0d", k, palette_idx, (k / 2) % 4); end
        end
        n_checks++;
        if (dut_fs_cnt - fs0 != 8) begin n_fail++;
            $display("FAIL fs_count: got %0d want 8", dut_fs_cnt - fs0); end
    endtask

    task automatic test_force_midframe();
        active_in = 1'b1; noise_in = 8'h55;
        pal_force_en = 1'b1; pal_force_idx = 2'd2;
        repeat (6) begin
            cycle();
            n_checks++;
            if (palette_idx !== 2'd0) begin n_fail++;
                $display("FAIL force_hold: got %0d want 0", palette_idx); end
        end
        vpulse();
        n_checks++;
        if (palette_idx !== 2'd2) begin n_fail++;
            $display("FAIL force_apply: got %0d want 2", palette_idx); end
        pal_force_en = 1'b0;
        vpulse();
        n_checks++;
        if (palette_idx !== 2'd2) begin n_fail++;
            $display("FAIL force_cnt_clear: got %0d want 2", palette_idx); end
        vpulse();
        n_checks++;
        if (palette_idx !== 2'd3) begin n_fail++;
            $display("FAIL force_next: got %0d want 3", palette_idx); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            hsync_in      = ($urandom_range(0, 7) != 0);
            vsync_in      = ($urandom_range(0, 11) != 0);
            active_in     = $urandom_range(0, 3) != 0;
            x_in          = 2'($urandom);
            y_in          = 2'($urandom);
            noise_in      = 8'($urandom);
            pal_force_en  = ($urandom_range(0, 5) == 0);
            pal_force_idx = 2'($urandom);
            cycle();
            n_checks += 5;
            if (rrggbb_out !== exp_rgb) begin n_fail++;
                $display("FAIL rnd_rgb @%0d: got %h want %h", i, rrggbb_out, exp_rgb); end
            if (hsync_out !== exp_h) begin n_fail++;
                $display("FAIL rnd_hsync @%0d: got %b want %b", i, hsync_out, exp_h); end
            if (vsync_out !== exp_v) begin n_fail++;
                $display("FAIL rnd_vsync @%0d: got %b want %b", i, vsync_out, exp_v); end
            if (int'(palette_idx) != exp_pal) begin n_fail++;
                $display("FAIL rnd_pal @%0d: got %0d want %0d", i, palette_idx, exp_pal); end
            if (frame_start !== exp_fs) begin n_fail++;
                $display("FAIL rnd_fs @%0d: got %b want %b", i, frame_start, exp_fs); end
        end
        n_checks++;
        if (dut_fs_cnt != model_fs_cnt) begin n_fail++;
            $display("FAIL rnd_fs_total: got %0d want %0d", dut_fs_cnt, model_fs_cnt); end
    endtask

    task automatic test_reset_midframe();
        idle_inputs();
        force_pal(2'd3);
        hsync_in = 1'b0; vsync_in = 1'b0; active_in = 1'b1; noise_in = 8'hA4;
        repeat (L + 2) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks += 5;
        if (rrggbb_out !== 6'd0) begin n_fail++;
            $display("FAIL midrst_rgb: got %h want 00", rrggbb_out); end
        if (hsync_out !== 1'b1) begin n_fail++;
            $display("FAIL midrst_hsync: got %b want 1", hsync_out); end
        if (vsync_out !== 1'b1) begin n_fail++;
            $display("FAIL midrst_vsync: got %b want 1", vsync_out); end
        if (palette_idx !== 2'd0) begin n_fail++;
            $display("FAIL midrst_pal: got %0d want 0", palette_idx); end
        if (frame_start !== 1'b0) begin n_fail++;
            $display("FAIL midrst_fs: got %b want 0", frame_start); end
        // vsync_in is still asserted: it counts as the first frame after reset.
        hsync_in = 1'b1; active_in = 1'b0;
        repeat (L + 1) cycle();
        vsync_in = 1'b1;
        repeat (L + 2) cycle();
        vpulse();
        n_checks += 2;
        if (palette_idx !== 2'd1) begin n_fail++;
            $display("FAIL midrst_first_frame: got %0d want 1", palette_idx); end
        if (int'(palette_idx) != exp_pal) begin n_fail++;
            $display("FAIL midrst_model: got %0d want %0d", palette_idx, exp_pal); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_latency();
        test_dither();
        test_palettes();
        test_rotation();
        test_force_midframe();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
